// File: rtl/alu_iter_exec_if.sv
// Request/result bundle for alu_iter_exec: operand request handshake, result
// handshake and status flags.
interface alu_iter_exec_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FUNCT   = 6,
  parameter int unsigned SHAMT_W = 5
);
  logic               i_valid;
  logic               o_ready;
  logic [FUNCT-1:0]   i_alu_sel;
  logic [DATA_W-1:0]  i_op_a;
  logic [DATA_W-1:0]  i_op_b;
  logic [SHAMT_W-1:0] i_shamt;
  logic [DATA_W-1:0]  o_result;
  logic               o_zero;
  logic               o_overflow;
  logic               o_valid;
  logic               i_res_ready;
  logic               o_busy;

  modport master (
    output i_valid, i_alu_sel, i_op_a, i_op_b, i_shamt, i_res_ready,
    input  o_ready, o_result, o_zero, o_overflow, o_valid, o_busy
  );

  modport slave (
    input  i_valid, i_alu_sel, i_op_a, i_op_b, i_shamt, i_res_ready,
    output o_ready, o_result, o_zero, o_overflow, o_valid, o_busy
  );
endinterface

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle ADD/AND/OR/XOR/SLT/LUI, bit-serial SRA,
// valid/ready on both request and result sides.
module alu_iter_exec #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FUNCT   = 6,
  parameter int unsigned SHAMT_W = 5
) (
  input logic            i_clk,
  input logic            i_reset,
  alu_iter_exec_if.slave bus
);
  localparam logic [FUNCT-1:0] SEL_AND = 6'b100100;
  localparam logic [FUNCT-1:0] SEL_OR  = 6'b100101;
  localparam logic [FUNCT-1:0] SEL_XOR = 6'b100110;
  localparam logic [FUNCT-1:0] SEL_SLT = 6'b101010;
  localparam logic [FUNCT-1:0] SEL_LUI = 6'b110110;
  localparam logic [FUNCT-1:0] SEL_SRA = 6'b000011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               ovf_q, ovf_d;
  logic [DATA_W-1:0]  sr_q, sr_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0]  sum;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_ovf;
  logic               slt;
  logic [DATA_W-1:0]  sr_next;

  assign sum     = bus.i_op_a + bus.i_op_b;
  assign slt     = $signed(bus.i_op_a) < $signed(bus.i_op_b);
  assign sr_next = {sr_q[DATA_W-1], sr_q[DATA_W-1:1]};

  // Unlisted select codes fall through to ADD, including its overflow flag.
  always_comb begin
    alu_res = sum;
    alu_ovf = (bus.i_op_a[DATA_W-1] == bus.i_op_b[DATA_W-1]) &&
              (sum[DATA_W-1] != bus.i_op_a[DATA_W-1]);
    case (bus.i_alu_sel)
      SEL_AND: begin alu_res = bus.i_op_a & bus.i_op_b; alu_ovf = 1'b0; end
      SEL_OR:  begin alu_res = bus.i_op_a | bus.i_op_b; alu_ovf = 1'b0; end
      SEL_XOR: begin alu_res = bus.i_op_a ^ bus.i_op_b; alu_ovf = 1'b0; end
      SEL_SLT: begin alu_res = {{(DATA_W-1){1'b0}}, slt}; alu_ovf = 1'b0; end
      SEL_LUI: begin alu_res = bus.i_op_b << 16; alu_ovf = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          if (bus.i_alu_sel == SEL_SRA) begin
            if (bus.i_shamt == '0) begin
              result_d = bus.i_op_b;
              ovf_d    = 1'b0;
              state_d  = S_DONE;
            end else begin
              sr_d    = bus.i_op_b;
              cnt_d   = bus.i_shamt;
              state_d = S_SHIFT;
            end
          end else begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        sr_d  = sr_next;
        cnt_d = cnt_q - 1'b1;
        // The final shift lands straight in the result register.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = sr_next;
          ovf_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.i_res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      sr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_ready    = (state_q == S_IDLE);
  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_valid    = (state_q == S_DONE);
  assign bus.o_result   = result_q;
  assign bus.o_zero     = (result_q == '0);
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_alu_iter_exec.sv
// Bench for alu_iter_exec: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_alu_iter_exec;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FUNCT   = 6;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [5:0] C_ADD = 6'b100000;
  localparam logic [5:0] C_AND = 6'b100100;
  localparam logic [5:0] C_OR  = 6'b100101;
  localparam logic [5:0] C_XOR = 6'b100110;
  localparam logic [5:0] C_SLT = 6'b101010;
  localparam logic [5:0] C_LUI = 6'b110110;
  localparam logic [5:0] C_SRA = 6'b000011;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  int unsigned passed = 0;
  int unsigned total  = 0;

  alu_iter_exec_if #(.DATA_W(DATA_W), .FUNCT(FUNCT), .SHAMT_W(SHAMT_W)) bus ();

  alu_iter_exec #(.DATA_W(DATA_W), .FUNCT(FUNCT), .SHAMT_W(SHAMT_W)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  function automatic void model(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic ovf,
                                output int lat);
    longint sa, sb, s, maxv, minv;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    maxv = (longint'(1) <<< 31) - 1;
    minv = -(longint'(1) <<< 31);
    ovf  = 1'b0;
    lat  = 1;
    case (sel)
      C_AND: r = a & b;
      C_OR:  r = a | b;
      C_XOR: r = a ^ b;
      C_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      C_LUI: r = {b[15:0], 16'h0000};
      C_SRA: begin
        r   = $signed(b) >>> sh;
        lat = (sh == 5'd0) ? 1 : int'(sh) + 1;
      end
      default: begin
        s   = sa + sb;
        r   = s[31:0];
        ovf = (s > maxv) || (s < minv);
      end
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
    check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    check({tag, "_result"}, bus.o_result, 32'd0);
    check({tag, "_zero"}, 32'(bus.o_zero), 32'd1);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_ovf"}, 32'(bus.o_overflow), 32'd0);
  endtask

  // Issue one operation from IDLE, check latency/result, hold under
  // backpressure for 'hold' cycles, then release back to IDLE.
  task automatic run_op(input string tag, input logic [5:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int hold, input bit junk);
    logic [31:0] er;
    logic eo;
    int lat;
    model(sel, a, b, sh, er, eo, lat);
    check({tag, "_ready_pre"}, 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_alu_sel = sel;
    bus.i_op_a = a;
    bus.i_op_b = b;
    bus.i_shamt = sh;
    bus.i_res_ready = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      step();
      bus.i_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      if (junk) begin
        bus.i_alu_sel = 6'($urandom);
        bus.i_op_a = $urandom;
        bus.i_op_b = $urandom;
        bus.i_shamt = 5'($urandom);
      end
      if (k < lat) begin
        check({tag, "_busy_mid"}, 32'(bus.o_busy), 32'd1);
        check({tag, "_ready_mid"}, 32'(bus.o_ready), 32'd0);
        check({tag, "_valid_early"}, 32'(bus.o_valid), 32'd0);
      end
    end
    check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    check({tag, "_result"}, bus.o_result, er);
    check({tag, "_zero"}, 32'(bus.o_zero), 32'(er == 32'd0));
    check({tag, "_ovf"}, 32'(bus.o_overflow), 32'(eo));
    check({tag, "_ready_done"}, 32'(bus.o_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, "_hold_valid"}, 32'(bus.o_valid), 32'd1);
      check({tag, "_hold_result"}, bus.o_result, er);
      check({tag, "_hold_zero"}, 32'(bus.o_zero), 32'(er == 32'd0));
    end
    bus.i_valid = 1'b0;
    bus.i_res_ready = 1'b1;
    step();
    check({tag, "_ready_post"}, 32'(bus.o_ready), 32'd1);
    check({tag, "_valid_post"}, 32'(bus.o_valid), 32'd0);
    check({tag, "_busy_post"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    logic [5:0] codes [8];
    logic [5:0] sel;
    logic [31:0] a, b;
    codes = '{C_ADD, C_AND, C_OR, C_XOR, C_SLT, C_LUI, C_SRA, C_SRA};

    bus.i_valid = 1'b0;
    bus.i_alu_sel = '0;
    bus.i_op_a = '0;
    bus.i_op_b = '0;
    bus.i_shamt = '0;
    bus.i_res_ready = 1'b0;

    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    step();
    check_reset_state("reset");

    run_op("add_ovf", C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0, 1'b0);
    run_op("slt", C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0, 1'b0);
    run_op("lui", C_LUI, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 0, 1'b0);
    run_op("sra4", C_SRA, 32'h1111_1111, 32'h8000_0000, 5'd4, 0, 1'b1);
    run_op("sra0", C_SRA, 32'h0, 32'h1234_5678, 5'd0, 0, 1'b0);
    run_op("sra31", C_SRA, 32'h0, 32'h4000_0000, 5'd31, 0, 1'b0);
    run_op("sra31n", C_SRA, 32'h0, 32'h8000_0001, 5'd31, 1, 1'b0);
    run_op("xor_bp", C_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 3, 1'b0);
    run_op("add_neg_ovf", C_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, 1'b0);
    run_op("other_code", 6'b000000, 32'h0000_0005, 32'hFFFF_FFFB, 5'd0, 0, 1'b0);

    // Reset mid-shift aborts with no result pulse.
    bus.i_valid = 1'b1;
    bus.i_alu_sel = C_SRA;
    bus.i_op_b = 32'hF000_000F;
    bus.i_shamt = 5'd10;
    step();
    bus.i_valid = 1'b0;
    repeat (3) step();
    check("abort_busy", 32'(bus.o_busy), 32'd1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check_reset_state("abort_shift");
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort_no_pulse", 32'(bus.o_valid), 32'd0);
    end

    // Reset while holding a result in DONE.
    bus.i_valid = 1'b1;
    bus.i_alu_sel = C_OR;
    bus.i_op_a = 32'h0000_00F0;
    bus.i_op_b = 32'h0000_000F;
    bus.i_res_ready = 1'b0;
    step();
    bus.i_valid = 1'b0;
    check("done_or_result", bus.o_result, 32'h0000_00FF);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check_reset_state("abort_done");
    step();
    check("abort_done_idle", 32'(bus.o_valid), 32'd0);

    for (int n = 0; n < 60; n++) begin
      sel = (n % 9 == 8) ? 6'($urandom) : codes[$urandom_range(0, 7)];
      a = $urandom;
      b = $urandom;
      if (n % 7 == 3) b = 32'h0000_0000;
      if (n % 11 == 5) begin a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; end
      run_op("rand", sel, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage ALU that consumes the 6-bit ALUSel code produced by the pipeline's ALU control logic, together with its operands.
- Single-cycle operations (ADD, AND, OR, XOR, SLT, LUI) produce a result one cycle after acceptance.
- SRA runs bit-serially, one bit position per cycle, to save area.
- A valid/ready handshake on both sides lets the hazard unit stall the pipeline while a shift is in progress.

Parameters:
DATA_W   32  operand/result width
FUNCT    6   ALU select width
SHAMT_W  5   shift amount width (log2 DATA_W)

Ports:
i_clk          in   1        clock, rising edge
i_reset        in   1        synchronous, active-high reset
i_valid        in   1        operation request
o_ready        out  1        unit can accept a request
i_alu_sel      in   FUNCT    ALUSel code
i_op_a         in   DATA_W   operand A (rs)
i_op_b         in   DATA_W   operand B (rt / immediate)
i_shamt        in   SHAMT_W  shift amount
o_result       out  DATA_W   registered result
o_zero         out  1        o_result == 0
o_overflow     out  1        signed overflow of ADD, else 0
o_valid        out  1        result available
i_res_ready    in   1        consumer takes result
o_busy         out  1        state != IDLE (stall request)

Behaviour:
Reset and clocking:
- One clock (i_clk). Reset is synchronous and active-high (i_reset).
- On reset: state=IDLE; o_result=0, o_zero=1, o_overflow=0, o_valid=0, o_busy=0, o_ready=1.
- Reset mid-shift or in DONE aborts the operation with no output pulse.

State machine (IDLE, SHIFT, DONE):
- Accept = i_valid & o_ready. o_ready = (state==IDLE). Inputs are sampled only on accept.
- IDLE, accept, sel != SRA: compute the result, register it, go to DONE. Latency is 1 cycle (o_valid high the cycle after accept).
- IDLE, accept, sel == SRA:
  - shamt == 0: o_result = op_b, go to DONE. Latency 1.
  - otherwise: load shift reg = op_b and counter = shamt, go to SHIFT.
- SHIFT: each cycle, shift reg = {sr[MSB], sr[MSB:1]} and counter decrements.
  - On the cycle counter==1, the shifted value is written to o_result and the FSM goes to DONE.
  - Total latency = shamt + 1 cycles.
- DONE: o_valid=1, and o_result/o_zero/o_overflow are held stable.
  - Leave for IDLE when i_res_ready=1. Holds indefinitely otherwise (backpressure).
  - No new accept in DONE; maximum throughput is 1 op per 2 cycles.
- i_valid while busy is ignored; the requester holds i_valid and the inputs.

Operations (any other code executes ADD):
- 100000 ADD: a+b mod 2^DATA_W. o_overflow = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
- 100100 AND: a&b.
- 100101 OR: a|b.
- 100110 XOR: a^b.
- 101010 SLT: signed a<b gives 1, else 0, zero-extended.
- 110110 LUI: {b[15:0], 16'b0}.
- 000011 SRA: b >>> shamt, arithmetic. Operand A is unused.

Flags:
- o_zero is derived from the registered result and updated only when a result is written.
- o_overflow is 0 for every operation except ADD.

Test Plan:
- Reset check: assert reset 2 cycles, then idle -> o_ready=1, o_valid=0, o_result=0, o_zero=1, o_busy=0.
- ADD overflow: sel=100000, a=0x7FFFFFFF, b=1, i_res_ready=1 -> next cycle o_valid=1, result=0x80000000, o_overflow=1, o_zero=0; following cycle o_ready=1.
- SLT and LUI, back to back:
  - SLT sel=101010, a=0xFFFFFFFF, b=1 -> result 1.
  - Then LUI sel=110110, b=0x00001234 -> result 0x12340000.
  - Each result valid exactly 1 cycle after its accept.
- SRA, nonzero shift: sel=000011, b=0x80000000, shamt=4 -> o_busy high, o_ready low for 4 cycles; valid 5 cycles after accept with result 0xF8000000.
  - i_valid pulses with other ops during the shift are ignored.
- SRA edge shifts:
  - shamt=0, b=0x12345678 -> result 0x12345678 at latency 1.
  - shamt=31, b=0x40000000 -> result 0, o_zero=1.
- Backpressure and abort:
  - XOR a=0xFF00FF00, b=0x0FF00FF0 with i_res_ready=0 for 3 cycles -> o_valid and result 0xF0F0F0F0 stable; returns to IDLE the cycle after i_res_ready=1.
  - SRA with shamt=10 and reset asserted mid-shift -> IDLE next cycle with reset outputs and no o_valid pulse.
